ctrl_input_conditioner: RTL

CTRL_INPUT_CONDITIONER -- requirements
Module: ctrl_input_conditioner

---
 rtl/ctrl_input_conditioner_if.sv | 24 ++
 rtl/ctrl_input_conditioner.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ctrl_input_conditioner_if.sv
// Pushbutton/switch conditioner bus: raw board inputs, PIO acks and sticky events.
interface ctrl_input_conditioner_if;
    logic [4:0] btn_n;
    logic       sw_manual;
    logic       continue_ack;
    logic [1:0] left_right_ack;
    logic [1:0] up_down_ack;
    logic       continue_evt;
    logic [1:0] left_right_evt;
    logic [1:0] up_down_evt;
    logic       manual_auto;

    // Board/PIO side: drives raw inputs and acks, observes events
    modport master (
        output btn_n, sw_manual, continue_ack, left_right_ack, up_down_ack,
        input  continue_evt, left_right_evt, up_down_evt, manual_auto
    );

    // Conditioner side
    modport slave (
        input  btn_n, sw_manual, continue_ack, left_right_ack, up_down_ack,
        output continue_evt, left_right_evt, up_down_evt, manual_auto
    );
endinterface

// File: rtl/ctrl_input_conditioner.sv
// Synchronizes and debounces 5 active-low pushbuttons and a mode switch,
// turning press edges into sticky, level-acked events for the PIO in_ports.
// Optional macro CTRL_INPUT_CONDITIONER_AUTOREPEAT_EN adds held-button
// autorepeat on left/right/up/down.
module ctrl_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input logic                     clk_clk,
    input logic                     reset_reset,
    ctrl_input_conditioner_if.slave bus
);
    localparam int unsigned N_IN  = 6;
    localparam int unsigned N_BTN = 5;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Released raw levels: buttons idle high, switch idle low (auto)
    localparam logic [N_IN-1:0] SYNC_IDLE = 6'b01_1111;
    localparam logic [N_IN-1:0] BTN_INV   = 6'b01_1111;

    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  level_c;
    logic [N_IN-1:0]  flip_c;
    logic [N_IN-1:0]  deb;
    logic [CNT_W-1:0] cnt [N_IN];
    logic [N_BTN-1:0] press_c;
    logic [N_BTN-1:0] rpt_c;
    logic [N_BTN-1:0] set_q;
    logic [N_BTN-1:0] evt;
    logic [N_BTN-1:0] ack_c;

    // Two-flop synchronizer on raw inputs, {switch, buttons}
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= {bus.sw_manual, bus.btn_n};
            sync2 <= sync1;
        end
    end

    assign level_c = sync2 ^ BTN_INV;
    assign press_c = flip_c[N_BTN-1:0] & level_c[N_BTN-1:0];
    assign ack_c   = {bus.up_down_ack, bus.left_right_ack, bus.continue_ack};

    // Debounced value adopts the synced level on the last mismatching cycle
    always_comb begin
        flip_c = '0;
        for (int i = 0; i < N_IN; i++) begin
            flip_c[i] = (level_c[i] != deb[i]) && (cnt[i] >= CNT_LAST);
        end
    end

    // Per-input mismatch counters; the >= compare keeps them from wrapping
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            deb <= '0;
            for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (level_c[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (flip_c[i]) begin
                    deb[i] <= level_c[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef CTRL_INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int unsigned N_DIR   = 4;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt [N_DIR];
    logic [N_DIR-1:0] rpt_first;

    // Repeat fires when the held timer reaches the delay (first) or period
    always_comb begin
        rpt_c = '0;
        for (int j = 0; j < N_DIR; j++) begin
            rpt_c[j+1] = deb[j+1] &&
                         (rpt_cnt[j] >= (rpt_first[j] ? DLY_LAST : PER_LAST));
        end
    end

    // Hold timers for the four direction buttons; release restarts them
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rpt_first <= '1;
            for (int j = 0; j < N_DIR; j++) rpt_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < N_DIR; j++) begin
                if (!deb[j+1]) begin
                    rpt_cnt[j]   <= '0;
                    rpt_first[j] <= 1'b1;
                end else if (rpt_c[j+1]) begin
                    rpt_cnt[j]   <= '0;
                    rpt_first[j] <= 1'b0;
                end else begin
                    rpt_cnt[j] <= rpt_cnt[j] + RPT_W'(1);
                end
            end
        end
    end
`else
    assign rpt_c = '0;
`endif

    // Sticky events: a set lands one cycle after the debounced edge and beats ack
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            set_q <= '0;
            evt   <= '0;
        end else begin
            set_q <= press_c | rpt_c;
            evt   <= set_q | (evt & ~ack_c);
        end
    end

    assign bus.continue_evt   = evt[0];
    assign bus.left_right_evt = evt[2:1];
    assign bus.up_down_evt    = evt[4:3];
    assign bus.manual_auto    = deb[5];
endmodule
